// File: rtl/chip8_framebuffer.sv
// CHIP-8 64x32 monochrome framebuffer: a stall-free VGA read port plus a
// command FSM that clears the screen, XORs sprite bytes and reads pixels.
module chip8_framebuffer #(
  parameter int AUTO_CLEAR = 1
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic [10:0] vga_addr,
  output logic        vga_pixel,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_x,
  input  logic [4:0]  cmd_y,
  input  logic [7:0]  cmd_data,
  output logic        done,
  output logic        collision,
  output logic        rd_pixel
);

  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_XOR_RD = 3'd2,
    S_XOR_WR = 3'd3,
    S_RD     = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam state_t RESET_STATE = (AUTO_CLEAR != 0) ? S_CLEAR : S_IDLE;

  function automatic logic [10:0] pixel_addr(input logic [4:0] y, input logic [5:0] x);
    return {y, x};
  endfunction

  logic        mem [0:2047];
  state_t      state_r;
  state_t      next_s;
  logic [5:0]  x_r;
  logic [4:0]  y_r;
  logic [7:0]  data_r;
  logic [10:0] cnt_r;
  logic        auto_r;
  logic        old_r;
  logic        accept_s;
  logic        we_s;
  logic        mem_we_s;
  logic        wdata_s;
  logic [10:0] b_addr_s;
  logic [5:0]  col_s;
  logic        pix_bit_s;
  logic        vga_pixel_r;
  logic        cmd_ready_r;
  logic        done_r;
  logic        collision_r;
  logic        rd_pixel_r;

  assign accept_s  = cmd_valid & (state_r == S_IDLE);
  // Column wraps inside the row: 6-bit add, no carry into y.
  assign col_s     = x_r + {3'b000, cnt_r[2:0]};
  assign pix_bit_s = data_r[3'd7 - cnt_r[2:0]];
  // Writes are held off while reset is high so memory survives reset untouched.
  assign mem_we_s  = we_s & ~reset;

  // Port B write: memory contents are deliberately never reset.
  always_ff @(posedge clk50) begin
    if (mem_we_s) begin
      mem[b_addr_s] <= wdata_s;
    end
  end

  // Port A read: non-blocking read returns the pre-write value on a collision.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      vga_pixel_r <= 1'b0;
    end else begin
      vga_pixel_r <= mem[vga_addr];
    end
  end

  // FSM state register.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode and port-B address/write control.
  always_comb begin
    next_s   = state_r;
    we_s     = 1'b0;
    wdata_s  = 1'b0;
    b_addr_s = pixel_addr(y_r, col_s);
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_CLEAR: next_s = S_CLEAR;
            OP_XOR:   next_s = S_XOR_RD;
            OP_READ:  next_s = S_RD;
            default:  next_s = S_IDLE;
          endcase
        end else begin
          next_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        we_s     = 1'b1;
        wdata_s  = 1'b0;
        b_addr_s = cnt_r;
        if (cnt_r == 11'd2047) begin
          next_s = auto_r ? S_IDLE : S_DONE;
        end else begin
          next_s = S_CLEAR;
        end
      end
      S_XOR_RD: begin
        next_s = S_XOR_WR;
      end
      S_XOR_WR: begin
        we_s    = 1'b1;
        wdata_s = old_r ^ pix_bit_s;
        if (cnt_r[2:0] == 3'd7) begin
          next_s = S_DONE;
        end else begin
          next_s = S_XOR_RD;
        end
      end
      S_RD: begin
        b_addr_s = pixel_addr(y_r, x_r);
        next_s   = S_DONE;
      end
      S_DONE: begin
        next_s = S_IDLE;
      end
      default: begin
        next_s = S_IDLE;
      end
    endcase
  end

  // Command latch, step counter, read-back and status registers.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      x_r         <= 6'd0;
      y_r         <= 5'd0;
      data_r      <= 8'd0;
      cnt_r       <= 11'd0;
      auto_r      <= (AUTO_CLEAR != 0);
      old_r       <= 1'b0;
      collision_r <= 1'b0;
      rd_pixel_r  <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= (RESET_STATE == S_IDLE);
    end else begin
      done_r      <= (state_r == S_DONE);
      cmd_ready_r <= (next_s == S_IDLE);
      if (accept_s) begin
        x_r         <= cmd_x;
        y_r         <= cmd_y;
        data_r      <= cmd_data;
        cnt_r       <= 11'd0;
        auto_r      <= 1'b0;
        collision_r <= 1'b0;
      end else if ((state_r == S_CLEAR) || (state_r == S_XOR_WR)) begin
        cnt_r <= cnt_r + 11'd1;
        if ((state_r == S_XOR_WR) && (old_r & pix_bit_s)) begin
          collision_r <= 1'b1;
        end
      end
      if (state_r == S_XOR_RD) begin
        old_r <= mem[b_addr_s];
      end
      if (state_r == S_RD) begin
        rd_pixel_r <= mem[b_addr_s];
      end
    end
  end

  assign vga_pixel = vga_pixel_r;
  assign cmd_ready = cmd_ready_r;
  assign done      = done_r;
  assign collision = collision_r;
  assign rd_pixel  = rd_pixel_r;

endmodule

// File: tb/tb_chip8_framebuffer.sv
// Randomised self-checking bench for chip8_framebuffer against a bit-array screen model.
// Instance a uses auto-clear, instance b does not; the idle one is held in reset.
module tb_chip8_framebuffer;

  localparam logic [1:0] OP_RSV   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  logic        clk50;
  logic        reset_a;
  logic        reset_b;
  logic [10:0] vga_addr;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_x;
  logic [4:0]  cmd_y;
  logic [7:0]  cmd_data;
  logic        vga_pixel_a, cmd_ready_a, done_a, collision_a, rd_pixel_a;
  logic        vga_pixel_b, cmd_ready_b, done_b, collision_b, rd_pixel_b;
  logic        use_b;
  logic        ready_m, done_m, vga_m;

  int          checks;
  int          errors;
  bit          model [0:2047];
  logic        hist [0:31];
  logic        done_after;

  chip8_framebuffer #(.AUTO_CLEAR(1)) dut_a (
    .clk50(clk50), .reset(reset_a), .vga_addr(vga_addr), .vga_pixel(vga_pixel_a),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op), .cmd_x(cmd_x),
    .cmd_y(cmd_y), .cmd_data(cmd_data), .done(done_a), .collision(collision_a),
    .rd_pixel(rd_pixel_a)
  );

  chip8_framebuffer #(.AUTO_CLEAR(0)) dut_b (
    .clk50(clk50), .reset(reset_b), .vga_addr(vga_addr), .vga_pixel(vga_pixel_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op), .cmd_x(cmd_x),
    .cmd_y(cmd_y), .cmd_data(cmd_data), .done(done_b), .collision(collision_b),
    .rd_pixel(rd_pixel_b)
  );

  assign ready_m = use_b ? cmd_ready_b : cmd_ready_a;
  assign done_m  = use_b ? done_b : done_a;
  assign vga_m   = use_b ? vga_pixel_b : vga_pixel_a;

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic clear_model();
    for (int a = 0; a < 2048; a++) model[a] = 1'b0;
  endtask

  task automatic model_xor(input int x, input int y, input logic [7:0] d, output bit coll);
    int a;
    coll = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = y * 64 + (x + i) % 64;
      if (d[7 - i]) begin
        if (model[a]) coll = 1'b1;
        model[a] = ~model[a];
      end
    end
  endtask

  // Issue one command from a negedge; lat = negedges from accept to done, -1 if none.
  task automatic send_cmd(input logic [1:0] op, input int x, input int y, input logic [7:0] d,
                          input int max_wait, output int lat);
    int k;
    lat = -1;
    done_after = 1'b0;
    cmd_op = op; cmd_x = x[5:0]; cmd_y = y[4:0]; cmd_data = d; cmd_valid = 1'b1;
    k = 0;
    while (!ready_m && k < 4000) begin
      @(negedge clk50);
      k++;
    end
    if (!ready_m) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk50);
    @(negedge clk50);
    cmd_valid = 1'b0;
    for (int j = 0; j <= max_wait; j++) begin
      if (j < 32) hist[j] = vga_m;
      if (done_m) begin
        lat = j;
        break;
      end
      @(negedge clk50);
    end
    if (lat >= 0) begin
      @(negedge clk50);
      done_after = done_m;
    end
  endtask

  // Pipelined sweep of all vga addresses; returns mismatch count versus the model.
  task automatic scan_vga(output int bad, output int first);
    bad = 0;
    first = -1;
    vga_addr = 11'd0;
    for (int a = 1; a <= 2048; a++) begin
      @(negedge clk50);
      if (vga_m !== model[a - 1]) begin
        if (first < 0) first = a - 1;
        bad++;
      end
      if (a < 2048) vga_addr = a[10:0];
    end
  endtask

  task automatic test_reset();
    @(negedge clk50);
    checks++; if (cmd_ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready_a: got %b want 0", cmd_ready_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a: got %b want 0", done_a); end
    checks++; if (collision_a !== 1'b0) begin errors++; $display("FAIL reset_collision_a: got %b want 0", collision_a); end
    checks++; if (rd_pixel_a !== 1'b0) begin errors++; $display("FAIL reset_rd_pixel_a: got %b want 0", rd_pixel_a); end
    checks++; if (vga_pixel_a !== 1'b0) begin errors++; $display("FAIL reset_vga_a: got %b want 0", vga_pixel_a); end
    checks++; if (cmd_ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b want 1", cmd_ready_b); end
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done_b: got %b want 0", done_b); end
  endtask

  task automatic test_abort_clear();
    int lat, bad, first, done_seen;
    bit coll;
    int px [5] = '{0, 32, 40, 56, 5};
    int py [5] = '{0, 15, 15, 31, 20};
    logic [7:0] pd [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h81};
    use_b = 1'b1;
    reset_b = 1'b0;
    @(negedge clk50);
    send_cmd(OP_CLEAR, 0, 0, 8'h00, 2100, lat);
    clear_model();
    checks++; if (lat !== 2049) begin errors++; $display("FAIL clear_latency: got %0d want 2049", lat); end
    checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL clear_done_width: got %b want 0", done_after); end
    for (int i = 0; i < 5; i++) begin
      send_cmd(OP_XOR, px[i], py[i], pd[i], 40, lat);
      model_xor(px[i], py[i], pd[i], coll);
      checks++; if (lat !== 17) begin errors++; $display("FAIL abort_fill_latency[%0d]: got %0d want 17", i, lat); end
    end
    cmd_op = OP_CLEAR; cmd_valid = 1'b1;
    @(posedge clk50);
    @(negedge clk50);
    cmd_valid = 1'b0;
    done_seen = 0;
    for (int j = 1; j <= 999; j++) begin
      @(negedge clk50);
      if (done_b) done_seen++;
    end
    reset_b = 1'b1;
    for (int a = 0; a < 999; a++) model[a] = 1'b0;
    @(negedge clk50);
    checks++; if (cmd_ready_b !== 1'b1) begin errors++; $display("FAIL abort_ready_in_reset: got %b want 1", cmd_ready_b); end
    checks++; if (vga_pixel_b !== 1'b0) begin errors++; $display("FAIL abort_vga_in_reset: got %b want 0", vga_pixel_b); end
    reset_b = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk50);
      if (done_b) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
    checks++; if (cmd_ready_b !== 1'b1) begin errors++; $display("FAIL abort_idle_ready: got %b want 1", cmd_ready_b); end
    scan_vga(bad, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_contents: %0d bad pixels (first %0d) want 0", bad, first); end
    reset_b = 1'b1;
    use_b = 1'b0;
  endtask

  task automatic test_auto_clear();
    int low_cnt, done_seen, bad, first;
    @(negedge clk50);
    reset_a = 1'b0;
    low_cnt = 0;
    done_seen = 0;
    while (!cmd_ready_a && low_cnt < 3000) begin
      if (done_a) done_seen++;
      low_cnt++;
      @(negedge clk50);
    end
    checks++; if (low_cnt !== 2048) begin errors++; $display("FAIL auto_clear_busy: got %0d cycles want 2048", low_cnt); end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL auto_clear_done: got %0d pulses want 0", done_seen); end
    clear_model();
    scan_vga(bad, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL auto_clear_screen: %0d bad pixels (first %0d) want 0", bad, first); end
  endtask

  task automatic test_xor(input int x, input int y, input logic [7:0] d, input string name);
    int lat, bad, first, a0;
    bit coll;
    logic pre, post;
    a0 = y * 64 + x;
    vga_addr = a0[10:0];
    @(negedge clk50);
    pre = model[a0];
    send_cmd(OP_XOR, x, y, d, 40, lat);
    model_xor(x, y, d, coll);
    post = model[a0];
    checks++; if (lat !== 17) begin errors++; $display("FAIL %s_latency: got %0d want 17", name, lat); end
    checks++; if (collision_a !== coll) begin errors++; $display("FAIL %s_collision: got %b want %b", name, collision_a, coll); end
    checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b want 0", name, done_after); end
    checks++; if (hist[2] !== pre) begin errors++; $display("FAIL %s_vga_read_before_write: got %b want %b", name, hist[2], pre); end
    checks++; if (hist[3] !== post) begin errors++; $display("FAIL %s_vga_after_write: got %b want %b", name, hist[3], post); end
    scan_vga(bad, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL %s_screen: %0d bad pixels (first %0d) want 0", name, bad, first); end
  endtask

  task automatic test_read_pixel(input int x, input int y, input string name);
    int lat;
    send_cmd(OP_READ, x, y, 8'h00, 20, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL %s_latency: got %0d want 2", name, lat); end
    checks++; if (rd_pixel_a !== model[y * 64 + x]) begin errors++; $display("FAIL %s_value: got %b want %b", name, rd_pixel_a, model[y * 64 + x]); end
  endtask

  task automatic test_reserved();
    int lat;
    bit coll;
    send_cmd(OP_XOR, 60, 0, 8'h80, 40, lat);
    model_xor(60, 0, 8'h80, coll);
    checks++; if (collision_a !== coll) begin errors++; $display("FAIL rsv_pre_collision: got %b want %b", collision_a, coll); end
    send_cmd(OP_RSV, 7, 7, 8'hFF, 20, lat);
    checks++; if (lat !== -1) begin errors++; $display("FAIL rsv_no_done: got %0d want -1", lat); end
    checks++; if (collision_a !== 1'b0) begin errors++; $display("FAIL rsv_collision_cleared: got %b want 0", collision_a); end
    checks++; if (cmd_ready_a !== 1'b1) begin errors++; $display("FAIL rsv_still_idle: got %b want 1", cmd_ready_a); end
  endtask

  task automatic test_busy_hold();
    int d1, d2, acc, extra;
    cmd_op = OP_CLEAR; cmd_valid = 1'b1;
    @(posedge clk50);
    @(negedge clk50);
    cmd_op = OP_READ; cmd_x = 6'd10; cmd_y = 5'd3;
    d1 = -1; d2 = -1; acc = -1; extra = 0;
    for (int j = 0; j <= 2070; j++) begin
      if (j > 0) @(negedge clk50);
      if (done_a) begin
        if (d1 < 0) d1 = j;
        else if (d2 < 0) d2 = j;
        else extra++;
      end
      if (acc >= 0 && cmd_valid) cmd_valid = 1'b0;
      else if (cmd_valid && cmd_ready_a) acc = j;
    end
    cmd_valid = 1'b0;
    clear_model();
    checks++; if (d1 !== 2049) begin errors++; $display("FAIL busy_clear_done: got %0d want 2049", d1); end
    checks++; if (acc !== 2049) begin errors++; $display("FAIL busy_held_accept: got %0d want 2049", acc); end
    checks++; if (d2 !== 2052) begin errors++; $display("FAIL busy_read_done: got %0d want 2052", d2); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_extra_done: got %0d want 0", extra); end
    checks++; if (rd_pixel_a !== model[202]) begin errors++; $display("FAIL busy_read_value: got %b want %b", rd_pixel_a, model[202]); end
  endtask

  task automatic test_random();
    int lat, r, x, y, last_x, last_y, bad, first;
    logic [7:0] d;
    bit coll, coll_exp;
    logic rd_exp;
    rd_exp = rd_pixel_a === 1'b1;
    last_x = 0; last_y = 0;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      x = $urandom_range(0, 63);
      y = $urandom_range(0, 31);
      d = 8'($urandom_range(0, 255));
      if (r < 6) begin
        send_cmd(OP_XOR, x, y, d, 40, lat);
        model_xor(x, y, d, coll);
        coll_exp = coll;
        last_x = x; last_y = y;
        checks++; if (lat !== 17) begin errors++; $display("FAIL rand_xor_latency[%0d]: got %0d want 17", n, lat); end
      end else if (r < 9) begin
        if ($urandom_range(0, 1) == 1) begin
          x = (last_x + $urandom_range(0, 7)) % 64;
          y = last_y;
        end
        send_cmd(OP_READ, x, y, d, 20, lat);
        rd_exp = model[y * 64 + x];
        coll_exp = 1'b0;
        checks++; if (lat !== 2) begin errors++; $display("FAIL rand_read_latency[%0d]: got %0d want 2", n, lat); end
      end else begin
        send_cmd(OP_RSV, x, y, d, 20, lat);
        coll_exp = 1'b0;
        checks++; if (lat !== -1) begin errors++; $display("FAIL rand_rsv_done[%0d]: got %0d want -1", n, lat); end
      end
      checks++; if (collision_a !== coll_exp) begin errors++; $display("FAIL rand_collision[%0d]: got %b want %b", n, collision_a, coll_exp); end
      checks++; if (rd_pixel_a !== rd_exp) begin errors++; $display("FAIL rand_rd_pixel[%0d]: got %b want %b", n, rd_pixel_a, rd_exp); end
    end
    scan_vga(bad, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_screen: %0d bad pixels (first %0d) want 0", bad, first); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_a = 1'b1; reset_b = 1'b1; use_b = 1'b0;
    vga_addr = 11'd0; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_x = 6'd0; cmd_y = 5'd0; cmd_data = 8'd0;
    repeat (3) @(negedge clk50);
    test_reset();
    test_abort_clear();
    test_auto_clear();
    test_xor(10, 3, 8'hA5, "xor_basic");
    test_read_pixel(10, 3, "read_lit");
    test_xor(10, 3, 8'hA5, "xor_repeat");
    test_read_pixel(10, 3, "read_unlit");
    test_xor(60, 0, 8'hFF, "xor_wrap");
    test_reserved();
    test_read_pixel(61, 0, "read_wrapped");
    test_busy_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_framebuffer.md
CHIP8_FRAMEBUFFER -- requirements
Module: chip8_framebuffer

Interface
REQ-001 Parameter AUTO_CLEAR, default 1: when 1, the block runs a full clear after reset deasserts.
REQ-002 clk50  input  1  system clock, 50 MHz.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 vga_addr  input  11  display read address, {row[4:0], col[5:0]}.
REQ-005 vga_pixel  output  1  pixel at vga_addr, registered.
REQ-006 cmd_valid  input  1  CPU command request.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_op  input  2  01 CLEAR, 10 XOR_BYTE, 11 READ_PIXEL, 00 reserved.
REQ-009 cmd_x  input  6  start column, 0-63.
REQ-010 cmd_y  input  5  row, 0-31.
REQ-011 cmd_data  input  8  sprite byte; bit7 is the leftmost pixel.
REQ-012 done  output  1  one-cycle pulse when a command completes.
REQ-013 collision  output  1  XOR_BYTE turned at least one lit pixel off.
REQ-014 rd_pixel  output  1  READ_PIXEL result.

Function
REQ-015 Storage SHALL be 2048x1 bits, dual-ported: port A is VGA read-only; port B is FSM read/write; address = y*64 + x.
REQ-016 vga_pixel SHALL equal mem[vga_addr] sampled exactly 1 clk50 cycle after vga_addr is presented, with no stalls, independent of FSM state.
REQ-017 On a same-cycle port-B write and port-A read of one address, vga_pixel SHALL return the pre-write value.
REQ-018 FSM states SHALL be IDLE, CLEAR, XOR_RD, XOR_WR, RD and DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE.
REQ-020 A command is accepted on the clock edge where cmd_valid & cmd_ready; cmd_op, cmd_x, cmd_y and cmd_data SHALL be latched on that edge.
REQ-021 A command with cmd_op 00 SHALL be accepted and then ignored: no done pulse, no state change.
REQ-022 CLEAR SHALL write 0 to addresses 0..2047 ascending, one per cycle, in the 2048 cycles after accept, then go to DONE.
REQ-023 XOR_BYTE SHALL process i = 0..7, each taking one XOR_RD cycle (read address y*64 + ((x+i) mod 64)) and one XOR_WR cycle (write old ^ cmd_data[7-i]): 16 cycles total, then DONE.
REQ-024 XOR_BYTE column arithmetic SHALL be 6-bit, wrapping 63 -> 0 within the same row with no row carry.
REQ-025 collision SHALL be cleared on accept of any command and set if any old & cmd_data[7-i] = 1; it SHALL hold until the next accept.
REQ-026 READ_PIXEL SHALL read y*64 + x in RD, load rd_pixel on the following edge, then go to DONE; rd_pixel holds until the next READ_PIXEL.
REQ-027 DONE SHALL last exactly 1 cycle with done = 1, then return to IDLE.
REQ-028 Command latency from accept edge to done high SHALL be 2049 cycles for CLEAR, 17 for XOR_BYTE and 2 for READ_PIXEL.
REQ-029 cmd_valid while busy SHALL be ignored; the CPU holds it until accepted.

Reset
REQ-030 Reset SHALL force the FSM to IDLE (AUTO_CLEAR=0) or CLEAR (AUTO_CLEAR=1); done=0, collision=0, rd_pixel=0, vga_pixel=0, cmd_ready per state.
REQ-031 Memory contents SHALL NOT be reset; reset mid-command aborts it with partial contents retained and no done pulse.
REQ-032 The auto-clear after reset SHALL take 2048 cycles with cmd_ready=0 and SHALL NOT pulse done.

Verification
REQ-033 Reset, AUTO_CLEAR=1 -> cmd_ready low 2048 cycles, no done; then vga_pixel=0 for all 2048 vga_addr.
REQ-034 XOR_BYTE x=10, y=3, data=8'hA5 on a clear screen -> done at +17 cycles, collision=0, addresses 202, 204, 207, 209 read 1 via vga_addr.
REQ-035 Repeat the same XOR_BYTE -> collision=1, those four pixels return to 0.
REQ-036 XOR_BYTE x=60, y=0, data=8'hFF -> addresses 60-63 and 0-3 set, address 64 unchanged (wrap with no row carry).
REQ-037 READ_PIXEL x=10, y=3 after REQ-034 -> rd_pixel=1 with done 2 cycles after accept; cmd_valid held during an active CLEAR -> not accepted until IDLE.
REQ-038 Assert reset at cycle 1000 of a CLEAR with AUTO_CLEAR=0 -> IDLE, no done, addresses 0..~998 read 0 and higher addresses keep their old data.
